// File: rtl/qosc_readout.sv
// Oscillator sample readout: optional decimation, a {re,im} sample FIFO and a byte-serial output stream.
// Optional feature: define QOSC_READOUT_DECIM_EN to enable decimation driven by the decim input.
module qosc_readout #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic [7:0]                   sample_re,
    input  logic [7:0]                   sample_im,
    input  logic [2:0]                   decim,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [7:0]                   out_data,
    output logic                         out_is_im,
    input  logic                         clr_ovf,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND_RE = 2'd1;
    localparam logic [1:0] SEND_IM = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [7:0]       hold_im_q, hold_im_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_is_im_q, out_is_im_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]      mem_q [DEPTH];

    logic             keep_c;
    logic             push_c;
    logic             pop_c;
    logic [15:0]      head_c;

    assign head_c = mem_q[rd_ptr_q];

`ifdef QOSC_READOUT_DECIM_EN
    // Keep-one-in-(decim+1) counter; decim is re-read on every strobe.
    logic [2:0] dcnt_q, dcnt_d;

    always_comb begin
        dcnt_d = dcnt_q;
        if (sample_valid) begin
            dcnt_d = (dcnt_q >= decim) ? 3'd0 : 3'(dcnt_q + 3'd1);
        end
    end

    assign keep_c = sample_valid && (dcnt_q == 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q <= 3'd0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end
`else
    logic unused_decim;
    assign unused_decim = ^decim;
    assign keep_c       = sample_valid;
`endif

    // Output sequencer: the head pair moves to the output/holding registers on pop.
    always_comb begin
        state_d     = state_q;
        hold_im_d   = hold_im_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_is_im_d = out_is_im_q;
        pop_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop_c       = 1'b1;
                    hold_im_d   = head_c[7:0];
                    out_data_d  = head_c[15:8];
                    out_is_im_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = SEND_RE;
                end
            end
            SEND_RE: begin
                if (out_ready) begin
                    out_data_d  = hold_im_q;
                    out_is_im_d = 1'b1;
                    state_d     = SEND_IM;
                end
            end
            SEND_IM: begin
                if (out_ready) begin
                    if (count_q != '0) begin
                        pop_c       = 1'b1;
                        hold_im_d   = head_c[7:0];
                        out_data_d  = head_c[15:8];
                        out_is_im_d = 1'b0;
                        state_d     = SEND_RE;
                    end else begin
                        out_valid_d = 1'b0;
                        out_is_im_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_is_im_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a same-edge pop frees the slot for a push into a full FIFO.
    always_comb begin
        push_c     = keep_c && ((count_q < CNT_W'(DEPTH)) || pop_c);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_c) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
        end
        if (pop_c) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
        end

        case ({push_c, pop_c})
            2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
            2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
            default: count_d = count_q;
        endcase

        if (keep_c && !push_c) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_im_q   <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_is_im_q <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_im_q   <= hold_im_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_is_im_q <= out_is_im_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage array needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push_c) begin
            mem_q[wr_ptr_q] <= {sample_re, sample_im};
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_is_im = out_is_im_q;
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_qosc_readout.sv
// Bench for qosc_readout: vector table plus directed sequences, output bytes checked through a scoreboard queue.
// Expected decimation follows QOSC_READOUT_DECIM_EN when the macro is given to the bench build as well.
module tb_qosc_readout;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             sample_valid;
    logic [7:0]       sample_re;
    logic [7:0]       sample_im;
    logic [2:0]       decim;
    logic             out_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_is_im;
    logic             clr_ovf;
    logic             overflow;
    logic [CNT_W-1:0] count;

    qosc_readout #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_re    (sample_re),
        .sample_im    (sample_im),
        .decim        (decim),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_is_im    (out_is_im),
        .clr_ovf      (clr_ovf),
        .overflow     (overflow),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] re;
        logic [7:0] im;
        logic [7:0] exp_first;
        logic [7:0] exp_second;
    } vec_t;

    vec_t       vecs [4];
    logic [8:0] exp_q [$];
    logic [8:0] exp_e;
    int         n_checks;
    int         n_pass;

    logic       pv, pr, prst, pim;
    logic [7:0] pd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one strobe across the next edge; sample_valid is left high for back-to-back use.
    task automatic send(input logic [7:0] re, input logic [7:0] im, input bit kept);
        sample_valid = 1'b1;
        sample_re    = re;
        sample_im    = im;
        if (kept) begin
            exp_q.push_back({1'b0, re});
            exp_q.push_back({1'b1, im});
        end
        cyc();
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) cyc();
        check(name, 32'(exp_q.size()), 32'd0);
        cyc();
        check({name, "_count"}, 32'(count), 32'd0);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Monitor: consumes handshaken bytes and checks stability while stalled.
    always @(negedge clk) begin
        if (pv === 1'b1 && pr === 1'b0 && prst === 1'b0) begin
            check("hold_stable", {23'd0, out_valid, out_is_im, out_data}, {23'd0, 1'b1, pim, pd});
        end
        if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got byte 0x%0h is_im=%0b, required none", out_data, out_is_im);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_byte", {23'd0, out_is_im, out_data}, {23'd0, exp_e});
            end
        end
        pv   = out_valid;
        pr   = out_ready;
        prst = reset;
        pim  = out_is_im;
        pd   = out_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_re    = 8'd0;
        sample_im    = 8'd0;
        decim        = 3'd0;
        out_ready    = 1'b0;
        clr_ovf      = 1'b0;

        vecs[0] = '{8'h12, 8'h34, 8'h12, 8'h34};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'hA5, 8'h5A, 8'hA5, 8'h5A};

        repeat (3) cyc();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_is_im", 32'(out_is_im), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        reset = 1'b0;
        cyc();

        // Single-pair transfers: latency and byte order.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].re, vecs[i].im, 1'b1);
            sample_valid = 1'b0;
            check("lat_n_valid", 32'(out_valid), 32'd0);
            check("lat_n_count", 32'(count), 32'd1);
            cyc();
            check("lat_n1_valid", 32'(out_valid), 32'd1);
            check("lat_n1_re", {23'd0, out_is_im, out_data}, {24'd0, vecs[i].exp_first});
            cyc();
            check("lat_im", {23'd0, out_is_im, out_data}, {23'd0, 1'b1, vecs[i].exp_second});
            cyc();
            check("lat_done_valid", 32'(out_valid), 32'd0);
        end

        // Back-to-back pairs stream one byte per cycle.
        send(8'h21, 8'h22, 1'b1);
        send(8'h23, 8'h24, 1'b1);
        check("thr_valid", 32'(out_valid), 32'd1);
        send(8'h25, 8'h26, 1'b1);
        sample_valid = 1'b0;
        check("thr_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("thr_valid", 32'(out_valid), 32'd1);
        end
        cyc();
        check("thr_end_valid", 32'(out_valid), 32'd0);
        drain("thr_drain");

        // Stall in SEND_RE for three cycles.
        out_ready = 1'b0;
        send(8'h5C, 8'hC5, 1'b1);
        sample_valid = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            check("stall_re", {23'd0, out_valid, out_is_im, out_data}, {23'd0, 1'b1, 1'b0, 8'h5C});
            cyc();
        end
        drain("stall_drain");

        // Fill with out_ready low: first pair sits in the holding register, DEPTH more fill the FIFO, the next drops.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(8'(8'h40 + i), 8'(8'hB0 + i), i <= DEPTH);
        end
        sample_valid = 1'b0;
        check("ovf_count", 32'(count), DEPTH);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", 32'(out_data), 32'h40);
        clr_ovf = 1'b1;
        send(8'h4F, 8'hBF, 1'b0);
        sample_valid = 1'b0;
        clr_ovf      = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        check("ovf_full_count", 32'(count), DEPTH);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        drain("ovf_drain");

        // Decimation over nine strobes, spaced so the FIFO never fills.
        reset = 1'b1;
        exp_q.delete();
        cyc();
        reset     = 1'b0;
        decim     = 3'd2;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
`ifdef QOSC_READOUT_DECIM_EN
            send(8'(i), 8'(8'h80 | i), (i % 3) == 0);
`else
            send(8'(i), 8'(8'h80 | i), 1'b1);
`endif
            sample_valid = 1'b0;
            cyc();
            cyc();
        end
        drain("dec_drain");
        decim = 3'd0;

        // Reset in SEND_IM with two pairs queued discards everything.
        out_ready = 1'b0;
        send(8'h61, 8'h62, 1'b1);
        send(8'h63, 8'h64, 1'b1);
        send(8'h65, 8'h66, 1'b1);
        sample_valid = 1'b0;
        check("rst_pre_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        cyc();
        check("rst_pre_im", {23'd0, out_valid, out_is_im, out_data}, {23'd0, 1'b1, 1'b1, 8'h62});
        out_ready    = 1'b0;
        reset        = 1'b1;
        sample_valid = 1'b1;
        sample_re    = 8'hEE;
        sample_im    = 8'hEF;
        exp_q.delete();
        cyc();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_data", {23'd0, out_is_im, out_data}, 32'd0);
        sample_valid = 1'b0;
        reset        = 1'b0;
        out_ready    = 1'b1;
        repeat (10) cyc();
        check("rst_post_valid", 32'(out_valid), 32'd0);
        check("rst_post_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
